// File: rtl/gato_control_if.sv
// Button inputs and board/turn/result outputs of the tic-tac-toe game controller.
// Buttons are synchronized levels; outputs are registered, with no flow control.
interface gato_control_if;
  logic       btn_arriba;
  logic       btn_abajo;
  logic       btn_izq;
  logic       btn_der;
  logic       btn_marcar;
  logic       btn_reiniciar;
  logic [3:0] cuadrante_cursor;
  logic [8:0] tablero_x;
  logic [8:0] tablero_o;
  logic       turno;
  logic [1:0] estado_juego;
  logic [2:0] linea_ganadora;
  logic       jugada_invalida;

  modport master (
    output btn_arriba, btn_abajo, btn_izq, btn_der, btn_marcar, btn_reiniciar,
    input  cuadrante_cursor, tablero_x, tablero_o, turno, estado_juego,
           linea_ganadora, jugada_invalida
  );

  modport slave (
    input  btn_arriba, btn_abajo, btn_izq, btn_der, btn_marcar, btn_reiniciar,
    output cuadrante_cursor, tablero_x, tablero_o, turno, estado_juego,
           linea_ganadora, jugada_invalida
  );
endinterface

// File: rtl/gato_control.sv
// Tic-tac-toe controller: cursor and mark events act at the press edge, and win/draw is settled one edge later.
// No backpressure: each cycle one button edge is taken by priority, and the other edges are dropped.
module gato_control #(
  parameter logic [3:0] CURSOR_INICIAL = 4'd5,
  parameter logic       PRIMER_JUGADOR = 1'b0
) (
  input logic           clk,
  input logic           reset_n,
  gato_control_if.slave bus
);

  typedef enum logic [1:0] {JUGANDO, EVALUAR, FIN} fase_t;

  localparam logic [8:0] LINEAS [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                        9'h092, 9'h124, 9'h111, 9'h054};

  fase_t      r_fase;
  logic [5:0] r_btn_prev;
  logic [3:0] r_cursor;
  logic [8:0] r_tab_x;
  logic [8:0] r_tab_o;
  logic       r_turno;
  logic [1:0] r_estado;
  logic [2:0] r_linea;
  logic       r_invalida;

  logic [5:0] w_btn;
  logic [5:0] w_evt;
  logic [3:0] w_arriba, w_abajo, w_izq, w_der;
  logic [8:0] w_celda;
  logic       w_ocupada;
  logic [8:0] w_tablero;
  logic       w_gana;
  logic [2:0] w_linea;
  logic       w_lleno;

  // Bit order doubles as event priority: reiniciar is the MSB.
  assign w_btn = {bus.btn_reiniciar, bus.btn_marcar, bus.btn_arriba,
                  bus.btn_abajo, bus.btn_izq, bus.btn_der};
  assign w_evt = w_btn & ~r_btn_prev;

  assign w_arriba = (r_cursor > 4'd3) ? r_cursor - 4'd3 : r_cursor + 4'd6;
  assign w_abajo  = (r_cursor < 4'd7) ? r_cursor + 4'd3 : r_cursor - 4'd6;
  assign w_der    = (r_cursor == 4'd3 || r_cursor == 4'd6 || r_cursor == 4'd9)
                    ? r_cursor - 4'd2 : r_cursor + 4'd1;
  assign w_izq    = (r_cursor == 4'd1 || r_cursor == 4'd4 || r_cursor == 4'd7)
                    ? r_cursor + 4'd2 : r_cursor - 4'd1;

  assign w_celda   = 9'd1 << (r_cursor - 4'd1);
  assign w_ocupada = |((r_tab_x | r_tab_o) & w_celda);
  assign w_tablero = r_turno ? r_tab_o : r_tab_x;
  assign w_lleno   = &(r_tab_x | r_tab_o);

  // Scan from high to low so that the lowest matching line index is kept.
  always_comb begin
    w_gana  = 1'b0;
    w_linea = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if ((w_tablero & LINEAS[i]) == LINEAS[i]) begin
        w_gana  = 1'b1;
        w_linea = i[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fase     <= JUGANDO;
      r_btn_prev <= '1;
      r_cursor   <= CURSOR_INICIAL;
      r_tab_x    <= '0;
      r_tab_o    <= '0;
      r_turno    <= PRIMER_JUGADOR;
      r_estado   <= 2'b00;
      r_linea    <= 3'd0;
      r_invalida <= 1'b0;
    end else begin
      r_btn_prev <= w_btn;
      r_invalida <= 1'b0;
      if (w_evt[5]) begin
        r_fase   <= JUGANDO;
        r_cursor <= CURSOR_INICIAL;
        r_tab_x  <= '0;
        r_tab_o  <= '0;
        r_turno  <= PRIMER_JUGADOR;
        r_estado <= 2'b00;
        r_linea  <= 3'd0;
      end else begin
        case (r_fase)
          JUGANDO: begin
            if (w_evt[4]) begin
              if (w_ocupada) begin
                r_invalida <= 1'b1;
              end else begin
                if (r_turno) r_tab_o <= r_tab_o | w_celda;
                else         r_tab_x <= r_tab_x | w_celda;
                r_fase <= EVALUAR;
              end
            end else if (w_evt[3]) r_cursor <= w_arriba;
            else if (w_evt[2])     r_cursor <= w_abajo;
            else if (w_evt[1])     r_cursor <= w_izq;
            else if (w_evt[0])     r_cursor <= w_der;
          end
          EVALUAR: begin
            if (w_gana) begin
              r_estado <= r_turno ? 2'b10 : 2'b01;
              r_linea  <= w_linea;
              r_fase   <= FIN;
            end else if (w_lleno) begin
              r_estado <= 2'b11;
              r_fase   <= FIN;
            end else begin
              r_turno <= ~r_turno;
              r_fase  <= JUGANDO;
            end
          end
          FIN:     r_fase <= FIN;
          default: r_fase <= JUGANDO;
        endcase
      end
    end
  end

  assign bus.cuadrante_cursor = r_cursor;
  assign bus.tablero_x        = r_tab_x;
  assign bus.tablero_o        = r_tab_o;
  assign bus.turno            = r_turno;
  assign bus.estado_juego     = r_estado;
  assign bus.linea_ganadora   = r_linea;
  assign bus.jugada_invalida  = r_invalida;

endmodule

// File: tb/tb_gato_control.sv
// Scoreboard bench for gato_control: the stimulus queues expected snapshots tagged with a clock edge,
// and a negedge monitor pops and compares them.
module tb_gato_control;

  typedef struct packed {
    logic [3:0] cur;
    logic [8:0] x;
    logic [8:0] o;
    logic       t;
    logic [1:0] est;
    logic [2:0] lin;
    logic       inv;
  } snap_t;

  typedef struct {
    snap_t s;
    int    edge_n;
    int    id;
  } exp_t;

  localparam logic [5:0] B_RST = 6'b100000;
  localparam logic [5:0] B_MRK = 6'b010000;
  localparam logic [5:0] B_ABJ = 6'b000100;
  localparam logic [5:0] B_IZQ = 6'b000010;
  localparam logic [5:0] B_DER = 6'b000001;

  logic   clk;
  logic   reset_n;
  int     edges;
  int     n_checks;
  int     n_fail;
  int     n_id;
  int     cur;
  exp_t   sb[$];

  gato_control_if bus();

  gato_control #(.CURSOR_INICIAL(4'd5), .PRIMER_JUGADOR(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edges = 0;
  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    snap_t a;
    exp_t  e;
    a = '{cur: bus.cuadrante_cursor, x: bus.tablero_x, o: bus.tablero_o,
          t: bus.turno, est: bus.estado_juego, lin: bus.linea_ganadora,
          inv: bus.jugada_invalida};
    while (sb.size() > 0 && sb[0].edge_n <= edges) begin
      e = sb.pop_front();
      n_checks++;
      if (a !== e.s) begin
        n_fail++;
        $display("FAIL chk%0d edge%0d: got cur=%0d x=%h o=%h t=%0d est=%b lin=%0d inv=%0d, want cur=%0d x=%h o=%h t=%0d est=%b lin=%0d inv=%0d",
                 e.id, edges, a.cur, a.x, a.o, a.t, a.est, a.lin, a.inv,
                 e.s.cur, e.s.x, e.s.o, e.s.t, e.s.est, e.s.lin, e.s.inv);
      end
    end
  end

  task automatic step(input logic [5:0] b);
    {bus.btn_reiniciar, bus.btn_marcar, bus.btn_arriba,
     bus.btn_abajo, bus.btn_izq, bus.btn_der} = b;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_s(input int c, input logic [8:0] x, input logic [8:0] o,
                          input logic t, input logic [1:0] est,
                          input logic [2:0] lin, input logic inv);
    exp_t e;
    e.s      = '{cur: c[3:0], x: x, o: o, t: t, est: est, lin: lin, inv: inv};
    e.edge_n = edges;
    e.id     = n_id;
    n_id++;
    sb.push_back(e);
  endtask

  task automatic goto(input int q);
    int nd, nr;
    nd = ((q - 1) / 3 - (cur - 1) / 3 + 3) % 3;
    nr = ((q - 1) % 3 - (cur - 1) % 3 + 3) % 3;
    repeat (nd) begin step(B_ABJ); step(6'b0); end
    repeat (nr) begin step(B_DER); step(6'b0); end
    cur = q;
  endtask

  // Marks at q, then checks the state right after the evaluation edge.
  task automatic mark(input int q, input logic [8:0] x, input logic [8:0] o,
                      input logic t, input logic [1:0] est, input logic [2:0] lin);
    goto(q);
    step(B_MRK);
    step(6'b0);
    expect_s(q, x, o, t, est, lin, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_id     = 0;
    cur      = 5;
    reset_n  = 1'b0;
    step(B_DER);
    step(B_DER);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);

    // Holding der through reset release must not move the cursor.
    reset_n = 1'b1;
    step(B_DER);
    step(B_DER);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    step(B_DER);
    expect_s(6, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    step(B_DER);
    expect_s(4, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    step(B_RST);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    cur = 5;

    // X wins on the top row.
    mark(1, 9'h001, 9'h000, 1, 2'b00, 0);
    mark(4, 9'h001, 9'h008, 0, 2'b00, 0);
    mark(2, 9'h003, 9'h008, 1, 2'b00, 0);
    mark(5, 9'h003, 9'h018, 0, 2'b00, 0);
    mark(3, 9'h007, 9'h018, 0, 2'b01, 0);
    step(B_MRK);
    step(6'b0);
    step(B_DER);
    step(6'b0);
    step(B_IZQ);
    expect_s(3, 9'h007, 9'h018, 0, 2'b01, 0, 0);
    step(6'b0);
    step(B_RST);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    cur = 5;

    // Marking an occupied cell pulses jugada_invalida for one cycle.
    mark(5, 9'h010, 9'h000, 1, 2'b00, 0);
    step(B_MRK);
    expect_s(5, 9'h010, 9'h000, 1, 2'b00, 0, 1);
    step(6'b0);
    expect_s(5, 9'h010, 9'h000, 1, 2'b00, 0, 0);

    // Restart taken during EVALUAR.
    goto(1);
    step(B_MRK);
    expect_s(1, 9'h010, 9'h001, 1, 2'b00, 0, 0);
    step(B_RST);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    cur = 5;

    // marcar and der rise together: marcar wins and the cursor stays.
    step(B_MRK | B_DER);
    expect_s(5, 9'h010, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    expect_s(5, 9'h010, 9'h000, 1, 2'b00, 0, 0);
    step(B_RST);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    cur = 5;

    // Draw game.
    mark(1, 9'h001, 9'h000, 1, 2'b00, 0);
    mark(5, 9'h001, 9'h010, 0, 2'b00, 0);
    mark(9, 9'h101, 9'h010, 1, 2'b00, 0);
    mark(3, 9'h101, 9'h014, 0, 2'b00, 0);
    mark(7, 9'h141, 9'h014, 1, 2'b00, 0);
    mark(4, 9'h141, 9'h01C, 0, 2'b00, 0);
    mark(6, 9'h161, 9'h01C, 1, 2'b00, 0);
    mark(8, 9'h161, 9'h09C, 0, 2'b00, 0);
    mark(2, 9'h163, 9'h09C, 0, 2'b11, 0);
    step(B_RST);
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    cur = 5;

    // Asynchronous reset while EVALUAR is pending.
    step(B_MRK);
    #1 reset_n = 1'b0;
    expect_s(5, 9'h000, 9'h000, 0, 2'b00, 0, 0);
    step(6'b0);
    reset_n = 1'b1;
    repeat (3) step(6'b0);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gato_control.md
Name: gato_control

Overview:
- Game controller for the tic-tac-toe (gato) display path.
- Turns player button presses into cursor movement and mark placement, and holds the 3x3 board state.
- Alternates turns and detects win or draw.
- Drives the renderer's 4-bit quadrant select (1..9) and exports board, turn and result registers to the rest of the design.

Parameters:
- CURSOR_INICIAL, 5, quadrant (1..9) loaded into the cursor on reset and on restart.
- PRIMER_JUGADOR, 0, player that moves first after reset or restart (0 = X, 1 = O).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- btn_arriba  input  1  move cursor up (level, already synchronized)
- btn_abajo  input  1  move cursor down
- btn_izq  input  1  move cursor left
- btn_der  input  1  move cursor right
- btn_marcar  input  1  place current player's mark at cursor
- btn_reiniciar  input  1  restart game
- cuadrante_cursor  output  4  cursor quadrant 1..9 (row-major, 1 top-left), feeds renderer quadrant select
- tablero_x  output  9  X occupancy; bit i-1 = quadrant i
- tablero_o  output  9  O occupancy; same mapping
- turno  output  1  player to move (0 = X, 1 = O)
- estado_juego  output  2  00 playing, 01 X wins, 10 O wins, 11 draw
- linea_ganadora  output  3  winning line index; valid only when estado_juego is 01 or 10
- jugada_invalida  output  1  one-cycle pulse: mark attempted on an occupied cell

Behaviour:
- Reset (reset_n low, asynchronous):
  - cuadrante_cursor = CURSOR_INICIAL; tablero_x = tablero_o = 0; turno = PRIMER_JUGADOR.
  - estado_juego = 00; linea_ganadora = 0; jugada_invalida = 0; state = JUGANDO.
  - Edge-detect history registers reset to 1, so a button held through reset release does not fire until it is released and pressed again.
- Edge detection: an event fires at edge k when a button is sampled 1 at k and was 0 at k-1. Only events are acted on, never levels.
- Event priority per cycle: reiniciar > marcar > arriba > abajo > izq > der. Exactly one event is acted on; the rest are dropped.
- reiniciar, in any state: synchronously restores all reset values at the same edge.
- FSM states:
  - JUGANDO:
    - Move event updates the cursor at edge k.
    - marcar on an empty cell: set the bit in tablero_x or tablero_o per turno at edge k, go to EVALUAR.
    - marcar on an occupied cell: jugada_invalida = 1 for the cycle after edge k; board, turno and state unchanged.
  - EVALUAR (exactly 1 cycle; all button events ignored except reiniciar):
    - Check the mover's board against the 8 lines: 0-2 rows (top to bottom), 3-5 columns (left to right), 6 diagonal 1-5-9, 7 diagonal 3-5-7.
    - Win: estado_juego = 01 (X) or 10 (O), linea_ganadora = lowest matching index, go to FIN. turno is not toggled.
    - No win and all 9 cells occupied: estado_juego = 11, go to FIN.
    - Otherwise: toggle turno, return to JUGANDO.
    - All of these outputs update at edge k+1.
  - FIN: only reiniciar is accepted. Cursor and board stay frozen.
- Cursor moves wrap within the row or column:
  - right from 3 -> 1; left from 4 -> 6.
  - up from 2 -> 8; down from 9 -> 3.
  - cuadrante_cursor never leaves 1..9.
- Invariants: tablero_x & tablero_o == 0 at all times; popcount(tablero_x) - popcount(tablero_o) is 0 or 1 when PRIMER_JUGADOR = 0.
- Reset asserted mid-EVALUAR: the evaluation is abandoned and all reset values load immediately.

Test Plan:
- Reset release with btn_der held high, then release and press -> no move while held; after re-press, cursor 5 -> 6; press again -> 4 (wrap).
- Moves X@1, O@4, X@2, O@5, X@3 -> after the last mark's edge+1: estado_juego = 01, linea_ganadora = 0, tablero_x = 9'h007, tablero_o = 9'h018; further marcar/move ignored.
- X@5, then marcar again on 5 -> jugada_invalida high exactly 1 cycle; turno stays 1; tablero_o = 0.
- Full board with no line (X:1,2,6,7,9 / O:3,4,5,8), played as X1 O5 X9 O3 X7 O4 X6 O8 X2 -> estado_juego = 11; tablero_x = 9'h163; tablero_o = 9'h09C.
- btn_marcar and btn_der rise in the same cycle on an empty cell -> mark placed at the current cursor; cursor unchanged.
- btn_reiniciar during FIN and during EVALUAR -> boards cleared, cursor 5, turno 0, estado_juego 00 on the next edge.
